// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch and decode stages.
package rv32i_pkg;

    // Canonical NOP: ADDI x0, x0, 0
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    // Major opcodes, shared with id_stage
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    // A fetch address is legal only on a 4-byte boundary
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched word that arrived while ID was stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_ir,
    output logic        valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_ir
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    // Next entry state: clear beats load, load beats drain
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            ir_d    = in_ir;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            ir_q    <= 32'd0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign valid  = valid_q;
    assign out_pc = pc_q;
    assign out_ir = ir_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch stage: PC, single-outstanding imem fetch FSM and IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] ir,
    output logic        if_misalign
);

    import rv32i_pkg::*;

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        imem_req_q, imem_req_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] ir_q, ir_d;
    logic        if_misalign_q, if_misalign_d;

    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_ir;

    logic ack_take;
    logic id_open;
    logic skid_load;
    logic skid_drain;
    logic skid_empty_next;
    logic can_issue;

    assign ack_take        = (state_q == IF_WAIT) && imem_ack;
    assign id_open         = !if_valid_q || !stall;
    assign skid_load       = ack_take && !redirect_valid && !id_open;
    assign skid_drain      = skid_valid && id_open && !redirect_valid;
    assign skid_empty_next = !skid_load && (!skid_valid || skid_drain || redirect_valid);
    assign can_issue       = !skid_valid && id_open && !is_misaligned(pc_q);

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .drain  (skid_drain),
        .clear  (redirect_valid),
        .in_pc  (pc_q),
        .in_ir  (imem_rdata),
        .valid  (skid_valid),
        .out_pc (skid_pc),
        .out_ir (skid_ir)
    );

    // IF/ID register: flush first, then stall hold, then skid, then fresh ack data
    always_comb begin
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        ir_d          = ir_q;
        if_misalign_d = if_misalign_q;
        if (redirect_valid) begin
            ir_d = NOP_IR;
            if (is_misaligned(redirect_pc)) begin
                if_valid_d    = 1'b1;
                if_pc_d       = redirect_pc;
                if_misalign_d = 1'b1;
            end else begin
                if_valid_d    = 1'b0;
                if_misalign_d = 1'b0;
            end
        end else if (!id_open) begin
            if_valid_d = if_valid_q;
        end else if (skid_valid) begin
            if_valid_d    = 1'b1;
            if_pc_d       = skid_pc;
            ir_d          = skid_ir;
            if_misalign_d = 1'b0;
        end else if (ack_take) begin
            if_valid_d    = 1'b1;
            if_pc_d       = pc_q;
            ir_d          = imem_rdata;
            if_misalign_d = 1'b0;
        end else begin
            if_valid_d    = 1'b0;
            ir_d          = NOP_IR;
            if_misalign_d = 1'b0;
        end
    end

    // Fetch FSM and PC: redirect has priority, a killed request is drained in DROP
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        unique case (state_q)
            IF_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (can_issue) begin
                    state_d = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_ack) begin
                        state_d = IF_IDLE;
                    end else begin
                        state_d     = IF_DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (imem_ack) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = (skid_empty_next && (!if_valid_d || !stall)) ? IF_WAIT : IF_IDLE;
                end
            end
            IF_DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = IF_IDLE;
                end
            end
            default: state_d = IF_IDLE;
        endcase
        imem_req_d = (state_d != IF_IDLE);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IF_IDLE;
            pc_q          <= RESET_PC;
            drop_addr_q   <= 32'd0;
            imem_req_q    <= 1'b0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            ir_q          <= NOP_IR;
            if_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_addr_q   <= drop_addr_d;
            imem_req_q    <= imem_req_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            ir_q          <= ir_d;
            if_misalign_q <= if_misalign_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = (state_q == IF_DROP) ? drop_addr_q : pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign ir          = ir_q;
    assign if_misalign = if_misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage with a behavioural memory and fetch model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] ir;
    logic        if_misalign;

    typedef struct {
        logic        mis;
        logic [31:0] pc;
        logic [31:0] ir;
    } entry_t;

    entry_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Model and memory-responder state, owned by the stimulus process
    logic [31:0] model_pc;
    bit          halted;
    bit          busy;
    bit          stale;
    int          cnt;
    int          lat;
    logic [31:0] start_addr;
    int          phase;
    int          lat_min, lat_max;
    int          stall_pct, redir_pct, spur_pct;
    bit          force_redirect;
    logic [31:0] force_pc;

    // Monitor-owned bookkeeping
    entry_t mon_e;
    int     delivered = 0;
    int     mis_seen  = 0;
    int     last_cycle = 0;
    bit     have_last  = 0;

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .ir             (ir),
        .if_misalign    (if_misalign)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Forget all outstanding expectations, as a reset does
    task automatic resetModel();
        exp_q.delete();
        model_pc = 32'd0;
        halted   = 0;
        busy     = 0;
        stale    = 0;
        cnt      = 0;
    endtask

    // One cycle: memory responder, random stall/redirect, and expected-entry bookkeeping
    task automatic applyStimulus();
        bit          ack_now;
        logic [31:0] rpc;
        @(posedge clk);
        #1;
        ack_now    = 0;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (busy) begin
            checkOutput("addr_stable", imem_addr, start_addr);
            checkOutput("req_held", {31'd0, imem_req}, 32'd1);
            cnt++;
            if (cnt >= lat) begin
                imem_ack = 1'b1;
                busy     = 0;
                ack_now  = 1;
            end
        end else if (imem_req) begin
            if (halted) begin
                checkOutput("no_req_after_misalign", {31'd0, imem_req}, 32'd0);
            end else begin
                checkOutput("req_addr", imem_addr, model_pc);
            end
            busy       = 1;
            stale      = 0;
            cnt        = 0;
            lat        = $urandom_range(lat_max, lat_min);
            start_addr = imem_addr;
        end else if ($urandom_range(99, 0) < spur_pct) begin
            imem_ack = 1'b1;
        end

        stall          = ($urandom_range(99, 0) < stall_pct);
        redirect_valid = ($urandom_range(99, 0) < redir_pct);
        rpc            = $urandom_range(1023, 0) << 2;
        if ($urandom_range(15, 0) == 0) rpc = rpc | 32'd2;
        if (force_redirect) begin
            redirect_valid = 1'b1;
            rpc            = force_pc;
            force_redirect = 0;
        end
        redirect_pc = rpc;

        if (ack_now && !stale && !redirect_valid) begin
            exp_q.push_back('{mis: 1'b0, pc: model_pc, ir: imem_rdata});
            model_pc = model_pc + 32'd4;
        end
        if (redirect_valid) begin
            exp_q.delete();
            if (busy) stale = 1;
            model_pc = rpc;
            halted   = (rpc[1:0] != 2'b00);
            if (halted) exp_q.push_back('{mis: 1'b1, pc: rpc, ir: NOP});
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        checkOutput({tag, "_ir"}, ir, NOP);
        checkOutput({tag, "_pc"}, if_pc, 32'd0);
        checkOutput({tag, "_misalign"}, {31'd0, if_misalign}, 32'd0);
    endtask

    task automatic setPhase(input int p, input int lmin, input int lmax,
                            input int st, input int rd, input int sp);
        phase     = p;
        lat_min   = lmin;
        lat_max   = lmax;
        stall_pct = st;
        redir_pct = rd;
        spur_pct  = sp;
    endtask

    // Monitor: consumes the presented instruction whenever ID takes it and checks it in order
    always @(negedge clk) begin
        if (rst_n) begin
            if (!if_valid) begin
                checkOutput("bubble_ir", ir, NOP);
                checkOutput("bubble_misalign", {31'd0, if_misalign}, 32'd0);
            end else if (!stall && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_instr: got pc %h ir %h expected none (cycle %0d)", if_pc, ir, cycle);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("if_pc", if_pc, mon_e.pc);
                    checkOutput("ir", ir, mon_e.ir);
                    checkOutput("if_misalign", {31'd0, if_misalign}, {31'd0, mon_e.mis});
                    delivered++;
                    if (mon_e.mis) mis_seen++;
                    if (phase == 1) begin
                        if (have_last) checkOutput("phase1_gap", cycle - last_cycle, 32'd2);
                        last_cycle = cycle;
                        have_last  = 1;
                    end
                end
            end
        end
    end

    // Test sequence
    initial begin
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        force_redirect = 0;
        force_pc       = 32'd0;
        setPhase(0, 1, 1, 0, 0, 0);
        resetModel();

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;

        // Back-to-back fetch with one-cycle ack, no stall
        setPhase(1, 1, 1, 0, 0, 0);
        repeat (20) applyStimulus();

        // Fixed three-cycle latency
        setPhase(2, 3, 3, 0, 0, 0);
        repeat (60) applyStimulus();

        // Random latency, heavy stall, spurious acks while idle
        setPhase(3, 1, 4, 40, 0, 20);
        repeat (200) applyStimulus();

        // Add redirects (some misaligned) on top
        setPhase(4, 1, 4, 30, 6, 10);
        repeat (200) applyStimulus();

        // Reset while a request is in flight, then a late ack
        setPhase(4, 2, 4, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus();
            if (busy && !stale) break;
        end
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checkResetOutputs("midreset");
        resetModel();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;

        setPhase(4, 1, 4, 30, 6, 10);
        repeat (200) applyStimulus();

        // Misaligned redirect, no stall: fault entry and no further requests
        setPhase(5, 1, 3, 0, 0, 0);
        force_redirect = 1;
        force_pc       = 32'h0000_0102;
        repeat (15) applyStimulus();
        checkOutput("misalign_delivered", (mis_seen > 0) ? 32'd1 : 32'd0, 32'd1);

        // Resume near the top of the address space so the PC wraps
        force_redirect = 1;
        force_pc       = 32'hFFFF_FFF0;
        setPhase(5, 1, 1, 0, 0, 0);
        repeat (40) applyStimulus();

        checkOutput("delivered_enough", (delivered >= 100) ? 32'd1 : 32'd0, 32'd1);
        checkOutput("queue_drained", (exp_q.size() <= 1) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
